// File: rtl/fpu_int_pkg.sv
// Shared definitions for the FPU integer datapath blocks.
// Holds the divider state encoding and the default operand width.
package fpu_int_pkg;

  localparam int DIV_WID = 32;

  // FIX is only reachable when the divider is built with DIV_SIGNED_EN.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div64by32_seq_div_step.sv
// One radix-2 restoring divide step: shift {rem,qs} left by one, then
// trial-subtract the divisor and keep the difference if it did not go
// negative. Purely combinational so it can later be chained for radix-4.
module div_step #(
  parameter int WID = 32
) (
  input  logic [WID:0]   rem_i,
  input  logic [WID-1:0] qs_i,
  input  logic [WID-1:0] b_i,
  output logic [WID:0]   rem_o,
  output logic [WID-1:0] qs_o
);

  logic [WID+1:0] rem_sh;
  logic [WID:0]   diff;
  logic           fits;

  // Shift, compare and conditionally restore in a single combinational pass.
  always_comb begin
    rem_sh = {rem_i, qs_i[WID-1]};
    fits   = (rem_sh >= {2'b00, b_i});
    // The difference always fits in WID+1 bits whenever it is kept,
    // because the incoming remainder is strictly below the divisor.
    diff   = rem_sh[WID:0] - {1'b0, b_i};
    rem_o  = fits ? diff : rem_sh[WID:0];
    qs_o   = {qs_i[WID-2:0], fits};
  end

endmodule

// File: rtl/div64by32_seq.sv
// Sequential 64/32 unsigned restoring divider with ld/done handshake.
// Divide-by-zero and quotient overflow exit after one clock; otherwise
// one quotient bit is produced per clock in the DIV state.
// Optional feature: define DIV_SIGNED_EN to add the sgn input and the FIX
// state that applies two's-complement signs (truncating toward zero).
module div64by32_seq
  import fpu_int_pkg::*;
#(
  parameter int WID = DIV_WID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [2*WID-1:0] a,
  input  logic [WID-1:0]   b,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic [WID-1:0]   q,
  output logic [WID-1:0]   r,
  output logic             done,
  output logic             idle,
  output logic             dvz,
  output logic             ovf
);

  localparam int CW = $clog2(WID + 1);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WID:0]   rem_q, rem_d;
  logic [WID-1:0] qs_q, qs_d;
  logic [WID-1:0] b_q, b_d;
  logic [WID-1:0] q_q, q_d;
  logic [WID-1:0] r_q, r_d;
  logic           done_q, done_d;
  logic           dvz_q, dvz_d;
  logic           ovf_q, ovf_d;

  logic [2*WID-1:0] a_mag;
  logic [WID-1:0]   b_mag;
  logic [WID:0]     step_rem;
  logic [WID-1:0]   step_qs;

`ifdef DIV_SIGNED_EN
  logic           sgn_q, sgn_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic           a_neg, b_neg;
  logic           fix_ovf;
  logic [WID-1:0] fix_q, fix_r;

  // Signed operands are divided as magnitudes; the signs are reapplied in FIX.
  assign a_neg = sgn && a[2*WID-1];
  assign b_neg = sgn && b[WID-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // A negative quotient may reach -2^(WID-1); a positive one only 2^(WID-1)-1.
  assign fix_ovf = sgn_q && qs_q[WID-1] && (!neg_q || (qs_q[WID-2:0] != '0));
  assign fix_q   = neg_q  ? -qs_q : qs_q;
  assign fix_r   = rneg_q ? -rem_q[WID-1:0] : rem_q[WID-1:0];
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  div_step #(.WID(WID)) u_step (
    .rem_i (rem_q),
    .qs_i  (qs_q),
    .b_i   (b_q),
    .rem_o (step_rem),
    .qs_o  (step_qs)
  );

  // Next-state and datapath control for the IDLE/DIV/DONE(/FIX) sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves one
    // unassigned and no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qs_d    = qs_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = done_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (ld) begin
          done_d = 1'b0;
          dvz_d  = 1'b0;
          ovf_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          sgn_d  = sgn;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
`endif
          if (b_mag == '0) begin
            dvz_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (a_mag[2*WID-1:WID] >= b_mag) begin
            // The quotient cannot fit in WID bits.
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, a_mag[2*WID-1:WID]};
            qs_d    = a_mag[WID-1:0];
            b_d     = b_mag;
            cnt_d   = CW'(WID);
            state_d = DIV;
          end
        end
      end

      DIV: begin
        rem_d = step_rem;
        qs_d  = step_qs;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef DIV_SIGNED_EN
          state_d = FIX;
`else
          q_d     = step_qs;
          r_d     = step_rem[WID-1:0];
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end
      end

`ifdef DIV_SIGNED_EN
      FIX: begin
        if (fix_ovf) begin
          ovf_d = 1'b1;
          q_d   = '1;
          r_d   = '0;
        end else begin
          q_d   = fix_q;
          r_d   = fix_r;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qs_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qs_q    <= qs_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign done = done_q;
  assign dvz  = dvz_q;
  assign ovf  = ovf_q;
  assign idle = (state_q == IDLE) || (state_q == DONE);

endmodule
